curve_gamma_enc_stream: RTL and testbench
=========================================

CURVE_GAMMA_ENC_STREAM -- requirements
Module: curve_gamma_enc_stream

Interface
REQ-001 Parameter: LATENCY, default 2, meaning pixel-path pipeline depth in clk cycles; only the value 2 is supported.
REQ-002 clk  in  1  single system clock; every register updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 gamma_en  in  1  encode enable request; sampled only at frame start.
REQ-005 lut_wr_valid  in  1  LUT load strobe; one entry per asserted cycle.
REQ-006 lut_wr_data  in  8  LUT entry value; entries are written in address order starting at 0.
REQ-007 lut_wr_ready  out  1  high when a LUT load entry can be accepted.
REQ-008 lut_loaded  out  1  high when a complete 256-entry shadow table is waiting for frame start.
REQ-009 per_frame_vsync  in  1  input frame sync; active high.
REQ-010 per_frame_href  in  1  input line valid.
REQ-011 per_frame_clken  in  1  input pixel strobe.
REQ-012 per_img_Y  in  8  input linear-light pixel.
REQ-013 post_frame_vsync  out  1  per_frame_vsync delayed by LATENCY.
REQ-014 post_frame_href  out  1  per_frame_href delayed by LATENCY.
REQ-015 post_frame_clken  out  1  per_frame_clken delayed by LATENCY.
REQ-016 post_img_Y  out  8  encoded pixel, aligned with post_frame_clken.

Function
REQ-017 The block SHALL hold two 256x8 tables, ACTIVE and SHADOW.
- ACTIVE is used for lookup.
- SHADOW is the load target.
REQ-018 The load FSM SHALL have three states.
- IDLE: lut_wr_ready=1.
- LOADING: lut_wr_ready=1.
- PENDING: lut_wr_ready=0, lut_loaded=1.
REQ-019 Load transitions SHALL be as follows; every accepted entry increments the 8-bit write address wr_addr.
- IDLE, lut_wr_valid=1: SHADOW[0] <= lut_wr_data, wr_addr <= 1, state -> LOADING.
- LOADING, lut_wr_valid=1: SHADOW[wr_addr] <= lut_wr_data, wr_addr increments.
- LOADING, entry at address 255 accepted: wr_addr wraps to 0, state -> PENDING.
- LOADING, lut_wr_valid=0: no change (gaps are allowed).
REQ-020 Any lut_wr_valid asserted in PENDING SHALL be ignored, with no write and no address change.
REQ-021 Frame start SHALL be the cycle in which per_frame_vsync is 1 and its registered copy from the previous cycle is 0.
REQ-022 At frame start the block SHALL register gamma_en into en_frame, which is held constant for the whole frame.
REQ-023 At frame start in state PENDING, the block SHALL copy SHADOW to ACTIVE in that cycle, set state -> IDLE, and set table_valid=1.
- The copy takes effect for the first pixel of the new frame.
REQ-024 Frame start in IDLE or LOADING SHALL NOT change ACTIVE.
- A partial load keeps loading across frame starts.
REQ-025 Pipeline stage 1 SHALL register the input pixel and the three sync/enable signals.
REQ-026 Pipeline stage 2 SHALL produce post_img_Y.
- post_img_Y = ACTIVE[stage-1 pixel] when en_frame=1 and table_valid=1.
- post_img_Y = stage-1 pixel otherwise (bypass).
REQ-027 Latency SHALL be exactly 2 cycles from every input to every output, with or without bypass.
REQ-028 The pipeline SHALL advance every cycle with no stall.
REQ-029 post_img_Y SHALL be 0 when the aligned post_frame_clken is 0.
REQ-030 The ACTIVE-to-stage-2 lookup SHALL use the table contents that are valid in the cycle the pixel occupies stage 1.

Reset
REQ-031 On rst=1 the block SHALL set the following:
- all post_* outputs to 0;
- state to IDLE, lut_wr_ready=1, lut_loaded=0;
- wr_addr=0, en_frame=0, table_valid=0;
- the vsync history register to 0.
REQ-032 Reset SHALL NOT clear the table contents.
- table_valid=0 forces bypass until a complete table has been committed.
REQ-033 Reset asserted during LOADING or PENDING SHALL discard the partial or pending load.
- Loading restarts at address 0.
REQ-034 The first vsync high after reset SHALL count as a frame start.

Verification
REQ-035 Scenario 1, bypass after reset: reset, gamma_en=1, no load, one frame with pixels 0x00, 0x40, 0xFF -> post_img_Y = 0x00, 0x40, 0xFF, each 2 cycles after input.
REQ-036 Scenario 2, commit at frame start: load SHADOW[i] = 255-i (256 writes, some with valid gaps) -> lut_loaded=1 after the last write; next frame with gamma_en=1 and pixel 0x10 -> post_img_Y = 0xEF; lut_wr_ready returns to 1 after the frame start.
REQ-037 Scenario 3, write ignored in PENDING: in PENDING, drive lut_wr_valid=1 with data 0xAA for 5 cycles -> SHADOW unchanged; after commit, pixel 0x00 -> 0xFF.
REQ-038 Scenario 4, gamma_en change mid-frame: gamma_en toggles 1 -> 0 mid-frame with a valid table loaded -> remaining pixels are still encoded; next frame bypasses, so pixel 0x10 -> 0x10.
REQ-039 Scenario 5, reset mid-load: reset after 100 entries -> wr_addr=0; a new 256-entry load commits correctly, and the first new entry lands at address 0.
REQ-040 Scenario 6, sync alignment: per_frame_href pulse of 4 cycles and clken toggling each cycle -> post_* signals are identical waveforms shifted by exactly 2 cycles, and post_img_Y=0 whenever post_frame_clken=0.

Source files
------------

// File: rtl/curve_gamma_enc_stream.sv
// Streaming gamma encoder: 8-bit pixel lookup through a double-buffered 256-entry LUT.
// SHADOW is loaded entry by entry; it is committed to ACTIVE only at a frame start.
module curve_gamma_enc_stream #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gamma_en,
    input  logic       lut_wr_valid,
    input  logic [7:0] lut_wr_data,
    output logic       lut_wr_ready,
    output logic       lut_loaded,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_PENDING
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic       shadow_we;
    logic       commit;

    logic       vsync_q;
    logic       frame_start;
    logic       en_frame_q;
    logic       table_valid_q;

    logic [7:0] shadow_q [256];
    logic [7:0] active_q [256];

    // {vsync, href, clken} per stage; newest stage in the low bits.
    logic [3*LATENCY-1:0] sync_q;
    logic [7:0]           s1_y_q;
    logic [7:0]           post_y_q, post_y_d;

    assign frame_start = per_frame_vsync & ~vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        shadow_we = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lut_wr_valid) begin
                    shadow_we = 1'b1;
                    wr_addr_d = wr_addr_q + 8'd1;
                    state_d   = S_LOADING;
                end
            end
            S_LOADING: begin
                if (lut_wr_valid) begin
                    shadow_we = 1'b1;
                    wr_addr_d = wr_addr_q + 8'd1;
                    if (wr_addr_q == 8'hFF) begin
                        state_d = S_PENDING;
                    end
                end
            end
            S_PENDING: begin
                if (frame_start) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lut_wr_ready = (state_q != S_PENDING);
        lut_loaded   = (state_q == S_PENDING);
    end

    // Table storage is deliberately outside reset; table_valid_q gates its use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (shadow_we) begin
                shadow_q[wr_addr_q] <= lut_wr_data;
            end
            if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

    always_comb begin
        post_y_d = '0;
        if (sync_q[0]) begin
            post_y_d = (en_frame_q && table_valid_q) ? active_q[s1_y_q] : s1_y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            en_frame_q    <= 1'b0;
            table_valid_q <= 1'b0;
            sync_q        <= '0;
            s1_y_q        <= '0;
            post_y_q      <= '0;
        end else begin
            vsync_q <= per_frame_vsync;
            if (frame_start) begin
                en_frame_q <= gamma_en;
            end
            if (commit) begin
                table_valid_q <= 1'b1;
            end
            sync_q   <= {sync_q[3*LATENCY-4:0], per_frame_vsync, per_frame_href, per_frame_clken};
            s1_y_q   <= per_img_Y;
            post_y_q <= post_y_d;
        end
    end

    assign post_frame_vsync = sync_q[3*LATENCY-1];
    assign post_frame_href  = sync_q[3*LATENCY-2];
    assign post_frame_clken = sync_q[3*LATENCY-3];
    assign post_img_Y       = post_y_q;

endmodule

// File: tb/tb_curve_gamma_enc_stream.sv
// Bench for curve_gamma_enc_stream: every driven cycle queues its expected
// post_* value, which a monitor checks exactly two cycles later.
module tb_curve_gamma_enc_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       gamma_en;
    logic       lut_wr_valid;
    logic [7:0] lut_wr_data;
    logic       lut_wr_ready;
    logic       lut_loaded;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_Y;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned cyc     = 0;

    typedef struct {
        int unsigned due;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];

    curve_gamma_enc_stream #(.LATENCY(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .gamma_en         (gamma_en),
        .lut_wr_valid     (lut_wr_valid),
        .lut_wr_data      (lut_wr_data),
        .lut_wr_ready     (lut_wr_ready),
        .lut_loaded       (lut_loaded),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: compares whole post_* bundle at its due cycle.
    always begin : monitor
        exp_t e;
        logic [10:0] act;
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            act = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y};
            n_total++;
            if (act !== e.exp)
                $display("FAIL stream cyc=%0d got vs/hr/ck/Y=%b/%b/%b/%h expected %b/%b/%b/%h",
                         cyc, act[10], act[9], act[8], act[7:0],
                         e.exp[10], e.exp[9], e.exp[8], e.exp[7:0]);
            else
                n_pass++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tbl(input int kind, input int i);
        logic [7:0] a;
        a = i[7:0];
        case (kind)
            0:       return 8'hFF - a;
            1:       return a ^ 8'h5A;
            2:       return a + 8'd1;
            default: return 8'h33;
        endcase
    endfunction

    task automatic step(input logic vs, input logic hr, input logic ck,
                        input logic [7:0] y, input logic [7:0] ey);
        exp_t e;
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_Y       = y;
        e.due = cyc + 2;
        e.exp = {vs, hr, ck, (ck ? ey : 8'h00)};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic en);
        gamma_en = en;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic load_table(input int kind, input int first, input int count, input bit gaps);
        for (int i = first; i < first + count; i++) begin
            if (gaps && (i % 7 == 3)) begin
                lut_wr_valid = 1'b0;
                step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            lut_wr_valid = 1'b1;
            lut_wr_data  = tbl(kind, i);
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        lut_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        lut_wr_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_total++;
        if ({lut_wr_ready, lut_loaded} !== 2'b10)
            $display("FAIL reset_flags got ready/loaded=%b%b expected 10", lut_wr_ready, lut_loaded);
        else
            n_pass++;
        n_total++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y} !== 11'h000)
            $display("FAIL reset_outputs got %b%b%b/%h expected 000/00",
                     post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y);
        else
            n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_bypass();
        frame(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h40, 8'h40);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_commit();
        load_table(0, 0, 256, 1'b1);
        n_total++;
        if ({lut_wr_ready, lut_loaded} !== 2'b01)
            $display("FAIL commit_pending got ready/loaded=%b%b expected 01", lut_wr_ready, lut_loaded);
        else
            n_pass++;
        gamma_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        n_total++;
        if ({lut_wr_ready, lut_loaded} !== 2'b10)
            $display("FAIL commit_ready got ready/loaded=%b%b expected 10", lut_wr_ready, lut_loaded);
        else
            n_pass++;
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'hEF);
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_pending_ignore();
        load_table(0, 0, 256, 1'b0);
        lut_wr_valid = 1'b1;
        lut_wr_data  = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            n_total++;
            if ({lut_wr_ready, lut_loaded} !== 2'b01)
                $display("FAIL pending_hold k=%0d got ready/loaded=%b%b expected 01",
                         k, lut_wr_ready, lut_loaded);
            else
                n_pass++;
        end
        lut_wr_valid = 1'b0;
        frame(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 8'h80, 8'h7F);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_gamma_toggle();
        load_table(1, 0, 256, 1'b0);
        n_total++;
        if (lut_loaded !== 1'b1)
            $display("FAIL toggle_loaded got %b expected 1", lut_loaded);
        else
            n_pass++;
        frame(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h10, tbl(1, 8'h10));
        gamma_en = 1'b0;
        step(1'b0, 1'b1, 1'b1, 8'h20, tbl(1, 8'h20));
        step(1'b0, 1'b1, 1'b1, 8'hFF, tbl(1, 8'hFF));
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        frame(1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h10);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_load();
        load_table(3, 0, 100, 1'b0);
        do_reset();
        load_table(2, 0, 128, 1'b0);
        n_total++;
        if ({lut_wr_ready, lut_loaded} !== 2'b10)
            $display("FAIL midload_partial got ready/loaded=%b%b expected 10", lut_wr_ready, lut_loaded);
        else
            n_pass++;
        // No committed table since reset: this frame must bypass.
        frame(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h10);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        load_table(2, 128, 128, 1'b0);
        n_total++;
        if ({lut_wr_ready, lut_loaded} !== 2'b01)
            $display("FAIL midload_done got ready/loaded=%b%b expected 01", lut_wr_ready, lut_loaded);
        else
            n_pass++;
        frame(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h11);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_sync_align();
        frame(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h05, 8'h06);
        step(1'b0, 1'b1, 1'b0, 8'h77, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hFE, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'h12, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h34, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] px;
        frame(1'b1);
        for (int k = 0; k < 16; k++) begin
            px = 8'($urandom_range(0, 255));
            step(1'b0, 1'b1, 1'b1, px, tbl(2, px));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        rst             = 1'b1;
        gamma_en        = 1'b0;
        lut_wr_valid    = 1'b0;
        lut_wr_data     = 8'h00;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Y       = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_bypass();
        test_commit();
        test_pending_ignore();
        test_gamma_toggle();
        test_reset_mid_load();
        test_sync_align();
        test_back_to_back();

        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_total++;
        if (sb.size() != 0)
            $display("FAIL drain got %0d pending entries expected 0", sb.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
